// File: rtl/gray_rate_sel_fb_if.sv
// Control and feedback bundle for gray_rate_sel_fb.
// The master drives the code words and frame control; the slave returns the feedback bits.
interface gray_rate_sel_fb_if #(
   parameter int WIDTH = 10,
   parameter int CH    = 2
);
   logic                en;
   logic                mode;
   logic [CH*WIDTH-1:0] code_in;
   logic                load;
   logic                load_ack;
   logic                frame_start;
   logic [CH-1:0]       out;

   modport master (
      output en, mode, code_in, load,
      input  load_ack, frame_start, out
   );

   modport slave (
      input  en, mode, code_in, load,
      output load_ack, frame_start, out
   );
endinterface

// File: rtl/gray_rate_sel_fb.sv
// Multi-channel gray-interleaved PDM / PWM feedback selector with double-buffered codes.
// Optional per-channel ones counter is enabled by defining GRAY_RATE_SEL_ONES_CNT_EN.
module gray_rate_sel_fb #(
   parameter int WIDTH = 10,
   parameter int CH    = 2
) (
   input  logic                    clk_ext,
   input  logic                    rst_ext,
`ifdef GRAY_RATE_SEL_ONES_CNT_EN
   output logic [CH*(WIDTH+1)-1:0] frame_ones,
`endif
   gray_rate_sel_fb_if.slave       bus
);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] MAXC = '1;

   logic [WIDTH-1:0]         cnt;
   logic [CH-1:0][WIDTH-1:0] shadow;
   logic [CH-1:0][WIDTH-1:0] active;
   logic                     pending;
   logic                     act_mode;

   logic [WIDTH-1:0] lz;
   logic [WIDTH-1:0] msk;
   logic [CH-1:0]    out_next;
   logic             wrap;
   logic             commit;

   assign wrap   = bus.en && (cnt == MAXC);
   assign commit = pending && (wrap || !bus.en);

   // Lowest zero of cnt marks the gray bit toggling this step; none when cnt is all ones.
   assign lz = ~cnt & (cnt + ONE);

   always_comb begin
      msk = '0;
      for (int i = 0; i < WIDTH; i++)
         msk[WIDTH-1-i] = lz[i];
   end

   always_comb begin
      out_next = '0;
      for (int c = 0; c < CH; c++) begin
         if (!bus.en)
            out_next[c] = 1'b0;
         else if (act_mode)
            out_next[c] = (cnt < active[c]);
         else
            out_next[c] = |(active[c] & msk);
      end
   end

   always_ff @(posedge clk_ext or posedge rst_ext) begin
      if (rst_ext) begin
         cnt             <= '0;
         shadow          <= '0;
         active          <= '0;
         pending         <= 1'b0;
         act_mode        <= 1'b0;
         bus.out         <= '0;
         bus.load_ack    <= 1'b0;
         bus.frame_start <= 1'b0;
      end else begin
         if (bus.en)
            cnt <= cnt + ONE;
         bus.out         <= out_next;
         bus.frame_start <= wrap;
         bus.load_ack    <= commit;
         if (commit)
            active <= shadow;
         if (wrap || commit)
            act_mode <= bus.mode;
         // A load on the commit edge is kept for the following frame.
         if (bus.load) begin
            shadow  <= bus.code_in;
            pending <= 1'b1;
         end else if (commit) begin
            pending <= 1'b0;
         end
      end
   end

`ifdef GRAY_RATE_SEL_ONES_CNT_EN
   logic [CH-1:0][WIDTH:0] acc;

   always_ff @(posedge clk_ext or posedge rst_ext) begin
      if (rst_ext) begin
         acc        <= '0;
         frame_ones <= '0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (wrap) begin
               acc[c] <= '0;
               frame_ones[c*(WIDTH+1) +: WIDTH+1] <=
                  acc[c] + {{WIDTH{1'b0}}, out_next[c]};
            end else begin
               acc[c] <= acc[c] + {{WIDTH{1'b0}}, out_next[c]};
            end
         end
      end
   end
`endif
endmodule

// File: tb/tb_gray_rate_sel_fb.sv
// Directed bench for gray_rate_sel_fb at WIDTH=4, CH=2.
// Expected frame patterns are hand-derived: bit k is the output for slot cnt=k.
module tb_gray_rate_sel_fb;
   localparam int W = 4;
   localparam int C = 2;

   logic clk_ext = 1'b0;
   logic rst_ext = 1'b1;
   int   n_chk   = 0;
   int   n_err   = 0;

`ifdef GRAY_RATE_SEL_ONES_CNT_EN
   logic [C*(W+1)-1:0] frame_ones;
`endif

   gray_rate_sel_fb_if #(.WIDTH(W), .CH(C)) bus ();

   gray_rate_sel_fb #(.WIDTH(W), .CH(C)) dut (
      .clk_ext    (clk_ext),
      .rst_ext    (rst_ext),
`ifdef GRAY_RATE_SEL_ONES_CNT_EN
      .frame_ones (frame_ones),
`endif
      .bus        (bus)
   );

   always #5 clk_ext = ~clk_ext;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_ext);
      #1;
   endtask

   task automatic ld(input logic [3:0] c1, input logic [3:0] c0);
      bus.code_in = {c1, c0};
      bus.load    = 1'b1;
      tick();
      bus.load    = 1'b0;
   endtask

   task automatic sync(output int n, output int acks);
      n    = 0;
      acks = 0;
      do begin
         tick();
         n++;
         if (bus.load_ack) acks++;
      end while (!bus.frame_start && n < 40);
   endtask

   task automatic grab(output logic [15:0] p0, output logic [15:0] p1,
                       output int fs, output int acks);
      p0   = '0;
      p1   = '0;
      fs   = 0;
      acks = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         p0[k] = bus.out[0];
         p1[k] = bus.out[1];
         if (bus.frame_start) fs = k + 1;
         if (bus.load_ack) acks++;
      end
   endtask

   logic [15:0] p0, p1;
   int          n, acks, fs;

   initial begin
      bus.en      = 1'b0;
      bus.mode    = 1'b0;
      bus.load    = 1'b0;
      bus.code_in = '0;
      tick();
      tick();
      chk("rst_out", 32'(bus.out), 0);
      chk("rst_ack", 32'(bus.load_ack), 0);
      chk("rst_fs", 32'(bus.frame_start), 0);

      // PDM: ch0=1010, ch1=0001
      rst_ext = 1'b0;
      bus.en  = 1'b1;
      ld(4'd1, 4'd10);
      sync(n, acks);
      chk("pdm_wrap_n", n, 15);
      chk("pdm_ack_cnt", acks, 1);
      chk("pdm_ack", 32'(bus.load_ack), 1);
      grab(p0, p1, fs, acks);
      chk("pdm_ch0", 32'(p0), 32'h5D5D);
      chk("pdm_ch1", 32'(p1), 32'h0080);
      chk("pdm_fs", fs, 16);
      chk("pdm_noack", acks, 0);
`ifdef GRAY_RATE_SEL_ONES_CNT_EN
      chk("ones_pdm", 32'(frame_ones), {22'd0, 5'd1, 5'd10});
`endif

      // PWM: ch0=5, ch1=15
      bus.mode = 1'b1;
      ld(4'd15, 4'd5);
      sync(n, acks);
      chk("pwm_wrap_n", n, 15);
      grab(p0, p1, fs, acks);
      chk("pwm5", 32'(p0), 32'h001F);
      chk("pwm15", 32'(p1), 32'h7FFF);
`ifdef GRAY_RATE_SEL_ONES_CNT_EN
      chk("ones_pwm", 32'(frame_ones), {22'd0, 5'd15, 5'd5});
`endif

      ld(4'd1, 4'd0);
      sync(n, acks);
      grab(p0, p1, fs, acks);
      chk("pwm0", 32'(p0), 32'h0000);
      chk("pwm1", 32'(p1), 32'h0001);

      // Two loads in one frame: last wins, single ack
      ld(4'd3, 4'd3);
      tick();
      ld(4'd9, 4'd9);
      sync(n, acks);
      chk("dbl_wrap_n", n, 13);
      chk("dbl_acks", acks, 1);
      grab(p0, p1, fs, acks);
      chk("dbl_pwm9", 32'(p0), 32'h01FF);
      chk("dbl_noack", acks, 0);

      // Load on the wrap edge itself
      ld(4'd2, 4'd2);
      for (int i = 0; i < 14; i++) tick();
      bus.code_in = {4'd6, 4'd6};
      bus.load    = 1'b1;
      tick();
      bus.load    = 1'b0;
      chk("wl_ack1", 32'(bus.load_ack), 1);
      chk("wl_fs", 32'(bus.frame_start), 1);
      grab(p0, p1, fs, acks);
      chk("wl_old", 32'(p0), 32'h0003);
      chk("wl_ack2", acks, 1);
      grab(p0, p1, fs, acks);
      chk("wl_new", 32'(p1), 32'h003F);
      chk("wl_noack", acks, 0);

      // en dropped at cnt=6 with a pending load
      ld(4'd3, 4'd10);
      for (int i = 0; i < 5; i++) tick();
      bus.en = 1'b0;
      tick();
      chk("hold_out", 32'(bus.out), 0);
      chk("hold_ack", 32'(bus.load_ack), 1);
      tick();
      chk("hold_out2", 32'(bus.out), 0);
      chk("hold_ack2", 32'(bus.load_ack), 0);
      bus.en = 1'b1;
      tick();
      chk("resume_out", 32'(bus.out), 32'h1);
      sync(n, acks);
      chk("resume_n", n, 9);

      // Asynchronous reset mid-frame with code 12 active
      ld(4'd12, 4'd12);
      sync(n, acks);
      chk("c12_ack", acks, 1);
      for (int i = 0; i < 3; i++) tick();
      chk("c12_out", 32'(bus.out), 32'h3);
      #2 rst_ext = 1'b1;
      #1;
      chk("arst_out", 32'(bus.out), 0);
      chk("arst_ack", 32'(bus.load_ack), 0);
      chk("arst_fs", 32'(bus.frame_start), 0);
      tick();
      rst_ext = 1'b0;
      grab(p0, p1, fs, acks);
      chk("post_ch0", 32'(p0), 0);
      chk("post_ch1", 32'(p1), 0);
      chk("post_fs", fs, 16);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
